// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the decode-side branch bus and the fetch-side PC
// outputs of the instruction-address sequencer. The master modport is the
// pipeline (decode/fetch) side; the slave modport is the sequencer itself.
interface pc_sequencer_if;
    logic       stall;
    logic       br_valid;
    logic       br_taken;
    logic       br_cond;
    logic       br_nullify;
    logic       br_backward;
    logic [7:0] br_ta;
    logic [7:0] br_ret;
    logic [7:0] front_pc;
    logic [7:0] back_pc;
    logic       squash;
    logic       link_we;
    logic [7:0] link_addr;

    modport master (
        output stall, br_valid, br_taken, br_cond, br_nullify, br_backward,
               br_ta, br_ret,
        input  front_pc, back_pc, squash, link_we, link_addr
    );

    modport slave (
        input  stall, br_valid, br_taken, br_cond, br_nullify, br_backward,
               br_ta, br_ret,
        output front_pc, back_pc, squash, link_we, link_addr
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the front/back PC pair and chooses, each cycle, between
// sequential advance, hold, and redirect to a branch target. Applies PA-RISC
// delayed-branch nullification of the delay slot. A branch that arrives while
// the pipeline is stalled is parked in pending registers (HOLD) and applied on
// the first unstalled edge.
// Optional feature: define PCSEQ_LINK_EN to build the link-register write
// port (link_we / link_addr); otherwise both outputs are tied to zero.
module pc_sequencer (
    input  logic             clk,
    input  logic             reset,
    pc_sequencer_if.slave    bus
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0] state;
    logic [7:0] front_q;
    logic [7:0] back_q;
    logic       squash_q;

    // Pending branch captured during a stall.
    logic       pend_taken;
    logic       pend_null;
    logic [7:0] pend_ta;

    logic       accept;
    logic       nullify_now;
    logic       apply_taken;
    logic       apply_null;
    logic [7:0] apply_ta;

    // A branch is accepted only in RUN and never from a nullified slot.
    assign accept = bus.br_valid && !squash_q && (state == ST_RUN);

    // Delay-slot nullify rule evaluated on the live branch fields.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        nullify_now = 1'b0;
        if (bus.br_nullify) begin
            if (!bus.br_cond)
                nullify_now = 1'b1;
            else if (bus.br_backward)
                nullify_now = !bus.br_taken;
            else
                nullify_now = bus.br_taken;
        end
    end

    // Select the decision to apply on an unstalled edge: pending in HOLD, live in RUN.
    always_comb begin
        apply_taken = 1'b0;
        apply_null  = 1'b0;
        apply_ta    = pend_ta;
        if (state == ST_HOLD) begin
            apply_taken = pend_taken;
            apply_null  = pend_null;
            apply_ta    = pend_ta;
        end else if (accept) begin
            apply_taken = bus.br_taken;
            apply_null  = nullify_now;
            apply_ta    = bus.br_ta;
        end
    end

    // PC pair, state, squash and pending-branch registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: the pending registers are reset too, so a branch parked in HOLD cannot leak past reset.
            state      <= ST_RUN;
            front_q    <= 8'h00;
            back_q     <= 8'h04;
            squash_q   <= 1'b0;
            pend_taken <= 1'b0;
            pend_null  <= 1'b0;
            pend_ta    <= 8'h00;
        end else if (bus.stall) begin
            if (accept) begin
                pend_taken <= bus.br_taken;
                pend_null  <= nullify_now;
                pend_ta    <= bus.br_ta;
                state      <= ST_HOLD;
            end
        end else begin
            state    <= ST_RUN;
            squash_q <= apply_null;
            if (apply_taken) begin
                front_q <= apply_ta;
                back_q  <= apply_ta + 8'd4;
            end else begin
                front_q <= back_q;
                back_q  <= back_q + 8'd4;
            end
        end
    end

    assign bus.front_pc = front_q;
    assign bus.back_pc  = back_q;
    assign bus.squash   = squash_q;

`ifdef PCSEQ_LINK_EN
    logic [7:0] pend_ret;
    logic [7:0] apply_ret;
    logic       link_we_q;
    logic [7:0] link_addr_q;

    // Return address that goes with the decision being applied.
    always_comb begin
        apply_ret = (state == ST_HOLD) ? pend_ret : bus.br_ret;
    end

    // Link write port: one-cycle pulse aligned with each taken redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_ret    <= 8'h00;
            link_we_q   <= 1'b0;
            link_addr_q <= 8'h00;
        end else if (bus.stall) begin
            link_we_q <= 1'b0;
            if (accept)
                pend_ret <= bus.br_ret;
        end else begin
            link_we_q <= apply_taken;
            if (apply_taken)
                link_addr_q <= apply_ret;
        end
    end

    assign bus.link_we   = link_we_q;
    assign bus.link_addr = link_addr_q;
`else
    // Return address is not consumed without the link port.
    logic unused_br_ret;
    assign unused_br_ret = ^bus.br_ret;

    assign bus.link_we   = 1'b0;
    assign bus.link_addr = 8'h00;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer. Each step drives the
// branch bus, pushes the expected post-edge outputs onto a scoreboard queue,
// clocks once, then pops and compares against the DUT. Link expectations
// collapse to zero when PCSEQ_LINK_EN is not defined.
module tb_pc_sequencer;

    typedef struct {
        string      tag;
        logic [7:0] front;
        logic [7:0] back;
        logic       squash;
        logic       link_we;
        logic [7:0] link_addr;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic lwe(input logic v);
`ifdef PCSEQ_LINK_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    function automatic logic [7:0] lad(input logic [7:0] v);
`ifdef PCSEQ_LINK_EN
        return v;
`else
        return 8'h00 & v;
`endif
    endfunction

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of stimulus, push expected outputs, clock, then pop and compare.
    task automatic step(input string tag,
                        input logic rst, input logic stl,
                        input logic bv, input logic bt, input logic bc,
                        input logic bn, input logic bb,
                        input logic [7:0] ta, input logic [7:0] ret,
                        input logic [7:0] e_front, input logic [7:0] e_back,
                        input logic e_sq, input logic e_lw, input logic [7:0] e_la);
        exp_t e;
        exp_t got;
        reset           = rst;
        bus.stall       = stl;
        bus.br_valid    = bv;
        bus.br_taken    = bt;
        bus.br_cond     = bc;
        bus.br_nullify  = bn;
        bus.br_backward = bb;
        bus.br_ta       = ta;
        bus.br_ret      = ret;
        e.tag       = tag;
        e.front     = e_front;
        e.back      = e_back;
        e.squash    = e_sq;
        e.link_we   = lwe(e_lw);
        e.link_addr = lad(e_la);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.tag, ".front_pc"},  bus.front_pc,          got.front);
        check({got.tag, ".back_pc"},   bus.back_pc,           got.back);
        check({got.tag, ".squash"},    {7'd0, bus.squash},    {7'd0, got.squash});
        check({got.tag, ".link_we"},   {7'd0, bus.link_we},   {7'd0, got.link_we});
        check({got.tag, ".link_addr"}, bus.link_addr,         got.link_addr);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.stall = 1'b0; bus.br_valid = 1'b0; bus.br_taken = 1'b0; bus.br_cond = 1'b0;
        bus.br_nullify = 1'b0; bus.br_backward = 1'b0; bus.br_ta = 8'h00; bus.br_ret = 8'h00;
        #2;

        //     tag          rst stl bv bt bc bn bb  ta     ret    front  back  sq lw la
        // Reset state, then four sequential fetches.
        step("reset",       1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h04, 0, 0, 8'h00);
        step("seq1",        0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h04, 8'h08, 0, 0, 8'h00);
        step("seq2",        0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h08, 8'h0C, 0, 0, 8'h00);
        step("seq3",        0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h0C, 8'h10, 0, 0, 8'h00);
        step("seq4",        0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h10, 8'h14, 0, 0, 8'h00);

        // Preload 0xF8 through an unconditional taken branch (n=0), then wrap.
        step("pre_f8",      0, 0, 1, 1, 0, 0, 0, 8'hF8, 8'h18, 8'hF8, 8'hFC, 0, 1, 8'h18);
        step("wrap_fc",     0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFC, 8'h00, 0, 0, 8'h18);
        step("wrap_00",     0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h04, 0, 0, 8'h18);

        // Forward conditional taken, n=1: redirect and nullify the delay slot once.
        step("fwd_n1",      0, 0, 1, 1, 1, 1, 0, 8'h40, 8'h08, 8'h40, 8'h44, 1, 1, 8'h08);
        step("fwd_n1_clr",  0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h44, 8'h48, 0, 0, 8'h08);
        // Same branch with n=0: no nullify.
        step("fwd_n0",      0, 0, 1, 1, 1, 0, 0, 8'h40, 8'h4C, 8'h40, 8'h44, 0, 1, 8'h4C);
        step("fwd_n0_nxt",  0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h44, 8'h48, 0, 0, 8'h4C);

        // Backward conditional not taken, n=1: sequential with squash.
        step("bwd_nt",      0, 0, 1, 0, 1, 1, 1, 8'h10, 8'h50, 8'h48, 8'h4C, 1, 0, 8'h4C);
        // br_valid presented from the nullified slot must be ignored.
        step("sq_ignore",   0, 0, 1, 1, 0, 0, 0, 8'h90, 8'h54, 8'h4C, 8'h50, 0, 0, 8'h4C);
        // Backward conditional taken, n=1: redirect, no squash.
        step("bwd_tk",      0, 0, 1, 1, 1, 1, 1, 8'h10, 8'h54, 8'h10, 8'h14, 0, 1, 8'h54);
        step("bwd_tk_nxt",  0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h14, 8'h18, 0, 0, 8'h54);

        // Branch arrives under a 3-cycle stall; later bus values in HOLD must not be captured.
        step("hold1",       0, 1, 1, 1, 0, 0, 0, 8'h20, 8'h1C, 8'h14, 8'h18, 0, 0, 8'h54);
        step("hold2",       0, 1, 1, 1, 0, 0, 0, 8'h60, 8'h66, 8'h14, 8'h18, 0, 0, 8'h54);
        step("hold3",       0, 1, 1, 1, 0, 0, 0, 8'h60, 8'h66, 8'h14, 8'h18, 0, 0, 8'h54);
        step("hold_apply",  0, 0, 1, 1, 0, 0, 0, 8'h20, 8'h1C, 8'h20, 8'h24, 0, 1, 8'h1C);
        step("hold_once",   0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h24, 8'h28, 0, 0, 8'h1C);

        // Squash persists through a stall and clears on the first unstalled edge.
        step("sq_set",      0, 0, 1, 1, 0, 1, 0, 8'h30, 8'h2C, 8'h30, 8'h34, 1, 1, 8'h2C);
        step("sq_stall",    0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h30, 8'h34, 1, 0, 8'h2C);
        step("sq_clear",    0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h34, 8'h38, 0, 0, 8'h2C);

        // Reset while HOLD carries target 0x80: pending branch discarded.
        step("rh_hold",     0, 1, 1, 1, 0, 1, 0, 8'h80, 8'h3C, 8'h34, 8'h38, 0, 0, 8'h2C);
        step("rh_reset",    1, 1, 1, 1, 0, 1, 0, 8'h80, 8'h3C, 8'h00, 8'h04, 0, 0, 8'h00);
        step("rh_after1",   0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h04, 8'h08, 0, 0, 8'h00);
        step("rh_after2",   0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h08, 8'h0C, 0, 0, 8'h00);

        check("sb_drained", 8'(sb.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-address sequencer that owns the front/back PC pair and decides, every cycle, whether fetch advances sequentially, holds, or redirects to a branch target. The target and return address come from the target address generator, which computes them from the front PC. The sequencer also applies PA-RISC delayed-branch rules: the delay-slot instruction is executed or nullified according to the n bit, the branch condition and the branch direction. It sits between the fetch stage and decode-stage branch resolution.

## Interface
Parameters:
- none (address width is fixed at 8 bits; instruction step is fixed at 4).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  pipeline freeze; PCs and state hold while high.
- `br_valid`  in  1  decode stage holds a resolved branch this cycle.
- `br_taken`  in  1  branch outcome; always 1 for unconditional branches.
- `br_cond`  in  1  1 = conditional branch, 0 = unconditional.
- `br_nullify`  in  1  n bit of the branch instruction.
- `br_backward`  in  1  sign bit of the branch displacement (1 = backward).
- `br_ta`  in  8  target address from the target address generator.
- `br_ret`  in  8  return address (front PC + 8) from the target address generator.
- `front_pc`  out  8  address currently being fetched; feeds the target address generator.
- `back_pc`  out  8  next sequential fetch address.
- `squash`  out  1  decode must kill its instruction (nullified delay slot).
- `link_we`  out  1  write-enable for the link register (see Configuration).
- `link_addr`  out  8  link value to write.

## Operation
- States:
  - RUN: normal operation.
  - HOLD: a branch is captured while `stall=1` and is waiting to be applied.
- RUN with `stall=0` and no branch: `front_pc` <= `back_pc`; `back_pc` <= `back_pc`+4.
- RUN with `stall=0`, `br_valid=1`, `br_taken=1`: `front_pc` <= `br_ta`; `back_pc` <= `br_ta`+4. The instruction fetched this cycle is the delay slot.
- RUN with `stall=0`, `br_valid=1`, `br_taken=0`: sequential advance.
- RUN with `stall=1` and `br_valid=1`: store `br_ta`, the decision and the nullify result into pending registers; go to HOLD. PCs hold.
- HOLD with `stall=1`: everything holds.
- HOLD with `stall=0`: apply the pending decision exactly as RUN would; return to RUN.
- In HOLD, `br_valid` is ignored. The decode stage keeps presenting the same branch while stalled, so it must not be captured twice.
- Nullify decision, computed when the branch is accepted:
  - n=0: never nullify.
  - n=1, unconditional: always nullify.
  - n=1, conditional, forward: nullify if taken.
  - n=1, conditional, backward: nullify if not taken.
- `squash` is registered. It is set in the cycle after the branch is applied, when the delay slot reaches decode. It stays high while `stall=1` and clears on the first cycle with `stall=0`.
- `br_valid` is ignored in any cycle where `squash=1`, because a nullified slot cannot branch.
- Arithmetic is 8-bit modulo: 0xFC+4 = 0x00, with no overflow flag.
- Reset during HOLD or while `squash` is set discards the pending branch and clears `squash`.

## Timing
- Reset values: `front_pc`=0x00, `back_pc`=0x04, `squash`=0, `link_we`=0, `link_addr`=0x00, state RUN, pending registers cleared.
- Redirect latency: `br_valid` sampled at edge N makes `front_pc`=`br_ta` visible after edge N (1 cycle).
- Squash latency: `squash` is high during cycle N+1 for a branch applied at edge N.
- Stall wins over everything except `reset`.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `PCSEQ_LINK_EN` defined:
  - On every accepted taken branch, `link_we` pulses for 1 cycle, aligned with the redirect.
  - `link_addr` = `br_ret` captured at acceptance. For a HOLD-applied branch, this is the value captured during HOLD.
  - The link fields are part of the pending state.
- `PCSEQ_LINK_EN` undefined: `link_we` and `link_addr` are tied to 0 and the link registers are not built.

## Test plan
- Reset, then 4 unstalled cycles -> `front_pc` goes 0x00, 0x04, 0x08, 0x0C, 0x10; `squash`=0 throughout.
- Sequential wrap: preload via a taken branch to 0xF8 (n=0), then run 3 cycles -> `front_pc` goes 0xF8, 0xFC, 0x00; `back_pc` = 0x04.
- Taken forward conditional branch, `br_ta`=0x40, n=1, `br_backward`=0 -> next `front_pc`=0x40 and `back_pc`=0x44; `squash`=1 for one cycle. Repeat with n=0 -> `squash` stays 0.
- Backward conditional branch, n=1, not taken -> sequential advance, `squash`=1. Taken -> `front_pc`=`br_ta`, `squash`=0.
- `br_valid` with `br_ta`=0x20 arrives while `stall=1` for 3 cycles, and `br_valid` stays high -> PCs frozen, state HOLD; on the first `stall=0` edge `front_pc`=0x20, the branch is applied once, and `link_we` pulses once when `PCSEQ_LINK_EN` is defined, with `link_addr`=`br_ret`.
- `reset` asserted during HOLD with a pending target of 0x80 -> after the edge, `front_pc`=0x00, `back_pc`=0x04, `squash`=0; 0x80 is never fetched.
